// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared 720p timing constants, coordinate/colour types and colour-bar palette
package video_pkg;

    localparam int H_ACTIVE_720P = 1280;
    localparam int H_FP_720P     = 110;
    localparam int H_SYNC_720P   = 40;
    localparam int H_BP_720P     = 220;
    localparam int V_ACTIVE_720P = 720;
    localparam int V_FP_720P     = 5;
    localparam int V_SYNC_720P   = 5;
    localparam int V_BP_720P     = 20;

    typedef logic signed [11:0] coord_t;

    // [2]=R, [1]=G, [0]=B
    typedef logic [2:0][7:0] rgb_t;

    localparam rgb_t BAR_WHITE   = 24'hFFFFFF;
    localparam rgb_t BAR_YELLOW  = 24'hFFFF00;
    localparam rgb_t BAR_CYAN    = 24'h00FFFF;
    localparam rgb_t BAR_GREEN   = 24'h00FF00;
    localparam rgb_t BAR_MAGENTA = 24'hFF00FF;
    localparam rgb_t BAR_RED     = 24'hFF0000;
    localparam rgb_t BAR_BLUE    = 24'h0000FF;
    localparam rgb_t BAR_BLACK   = 24'h000000;

    function automatic rgb_t bar_color(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vtg_counter.sv
// rtl/vtg_counter.sv - signed wrap counter running CNT_START..CNT_END with increment enable and wrap flag
module vtg_counter
    import video_pkg::*;
#(
    parameter coord_t CNT_START = '0,
    parameter coord_t CNT_END   = 12'sd1
) (
    input  logic   pixel_clk,
    input  logic   rst,
    input  logic   inc,
    output coord_t value,
    output logic   wrap
);

    assign wrap = inc && (value == CNT_END);

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            value <= CNT_START;
        end else if (inc) begin
            value <= wrap ? CNT_START : value + 12'sd1;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster counters plus registered RGB/DE/sync output stage; VTG_TEST_PATTERN_EN selects colour bars as fill
module video_timing_gen
    import video_pkg::*;
#(
    parameter int   H_ACTIVE  = H_ACTIVE_720P,
    parameter int   H_FP      = H_FP_720P,
    parameter int   H_SYNC    = H_SYNC_720P,
    parameter int   H_BP      = H_BP_720P,
    parameter int   V_ACTIVE  = V_ACTIVE_720P,
    parameter int   V_FP      = V_FP_720P,
    parameter int   V_SYNC    = V_SYNC_720P,
    parameter int   V_BP      = V_BP_720P,
    parameter bit   HSYNC_POL = 1'b1,
    parameter bit   VSYNC_POL = 1'b1,
    parameter rgb_t BG_COLOR  = 24'h000000
) (
    input  logic   pixel_clk,
    input  logic   rst,
    output coord_t hpos,
    output coord_t vpos,
    output logic   fsync,
    output logic   lsync,
    input  rgb_t   obj_pixel,
    input  logic   obj_active,
    output rgb_t   rgb,
    output logic   de,
    output logic   hsync,
    output logic   vsync
);

    localparam int H_BLANK = H_FP + H_SYNC + H_BP;
    localparam int V_BLANK = V_FP + V_SYNC + V_BP;

    localparam coord_t H_FIRST   = coord_t'(-H_BLANK);
    localparam coord_t H_LAST    = coord_t'(H_ACTIVE - 1);
    localparam coord_t V_FIRST   = coord_t'(-V_BLANK);
    localparam coord_t V_LAST    = coord_t'(V_ACTIVE - 1);
    localparam coord_t HS_FIRST  = coord_t'(H_FP - H_BLANK);
    localparam coord_t HS_LAST   = coord_t'(-H_BP - 1);
    localparam coord_t VS_FIRST  = coord_t'(V_FP - V_BLANK);
    localparam coord_t VS_LAST   = coord_t'(-V_BP - 1);

    if (H_BLANK > 2048 || H_ACTIVE - 1 > 2047 || V_BLANK > 2048 || V_ACTIVE - 1 > 2047) begin : g_range_check
        $error("video_timing_gen: timing parameters exceed 12-bit signed coordinate range");
    end

    logic h_wrap;
    logic v_wrap;
    logic first_line;
    logic active;
    logic h_sync_win;
    logic v_sync_win;
    rgb_t fill;

    vtg_counter #(
        .CNT_START (H_FIRST),
        .CNT_END   (H_LAST)
    ) u_hcnt (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .inc       (1'b1),
        .value     (hpos),
        .wrap      (h_wrap)
    );

    vtg_counter #(
        .CNT_START (V_FIRST),
        .CNT_END   (V_LAST)
    ) u_vcnt (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .inc       (h_wrap),
        .value     (vpos),
        .wrap      (v_wrap)
    );

    // High for the whole first line of a frame, so fsync needs no vpos compare
    always_ff @(posedge pixel_clk) begin
        if (rst || v_wrap) begin
            first_line <= 1'b1;
        end else if (h_wrap) begin
            first_line <= 1'b0;
        end
    end

    assign lsync      = !rst && (hpos == H_FIRST);
    assign fsync      = lsync && first_line;
    assign active     = !hpos[11] && !vpos[11];
    assign h_sync_win = (hpos >= HS_FIRST) && (hpos <= HS_LAST);
    assign v_sync_win = (vpos >= VS_FIRST) && (vpos <= VS_LAST);

`ifdef VTG_TEST_PATTERN_EN
    assign fill = bar_color(hpos[10:8]);
`else
    assign fill = BG_COLOR;
`endif

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            de    <= 1'b0;
            rgb   <= '0;
            hsync <= !HSYNC_POL;
            vsync <= !VSYNC_POL;
        end else begin
            de    <= active;
            hsync <= h_sync_win ? HSYNC_POL : !HSYNC_POL;
            vsync <= v_sync_win ? VSYNC_POL : !VSYNC_POL;
            rgb   <= !active ? '0 : (obj_active ? obj_pixel : fill);
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - self-checking bench for video_timing_gen on a reduced raster
module tb_video_timing_gen;
    import video_pkg::*;

    localparam int HA = 16, HF = 2, HS = 3, HB = 4;
    localparam int VA = 8, VF = 1, VS = 2, VB = 3;
    localparam int HBL = HF + HS + HB;
    localparam int VBL = VF + VS + VB;
    localparam logic [23:0] BG = 24'h123456;
`ifdef VTG_TEST_PATTERN_EN
    localparam logic [23:0] FILL = 24'hFFFFFF;
`else
    localparam logic [23:0] FILL = BG;
`endif

    logic   pixel_clk = 1'b0;
    logic   rst = 1'b1;
    coord_t hpos, vpos;
    logic   fsync, lsync, obj_active, de, hsync, vsync;
    rgb_t   obj_pixel, rgb;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .BG_COLOR(BG)
    ) dut (
        .pixel_clk  (pixel_clk),
        .rst        (rst),
        .hpos       (hpos),
        .vpos       (vpos),
        .fsync      (fsync),
        .lsync      (lsync),
        .obj_pixel  (obj_pixel),
        .obj_active (obj_active),
        .rgb        (rgb),
        .de         (de),
        .hsync      (hsync),
        .vsync      (vsync)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct {
        logic [23:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
    } exp_t;

    typedef struct {
        int          h;
        int          v;
        logic        act;
        logic [23:0] pix;
        logic [23:0] rgb;
        logic        de;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[7];
    int   tests = 0;
    int   fails = 0;
    int   ref_h, ref_v;
    int   n_fs, n_ls, n_de, n_hs, n_vs, fs_at, n;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at h=%0d v=%0d", name, act, act, exp, exp, ref_h, ref_v);
        end
    endtask

    task automatic tick(input logic r, input logic act, input logic [23:0] pix,
                        input logic ovr, input logic [23:0] o_rgb, input logic o_de);
        exp_t e;
        logic a;
        rst        = r;
        obj_active = act;
        obj_pixel  = pix;
        a = (ref_h >= 0) && (ref_v >= 0);
        if (r) begin
            e.rgb = 24'h0; e.de = 1'b0; e.hs = 1'b0; e.vs = 1'b0;
        end else begin
            e.de  = ovr ? o_de : a;
            e.rgb = ovr ? o_rgb : (!a ? 24'h0 : (act ? pix : FILL));
            e.hs  = (ref_h >= -HBL + HF) && (ref_h <= -HB - 1);
            e.vs  = (ref_v >= -VBL + VF) && (ref_v <= -VB - 1);
        end
        sb.push_back(e);
        @(posedge pixel_clk);
        if (r) begin
            ref_h = -HBL;
            ref_v = -VBL;
        end else if (ref_h == HA - 1) begin
            ref_h = -HBL;
            ref_v = (ref_v == VA - 1) ? -VBL : ref_v + 1;
        end else begin
            ref_h++;
        end
        @(negedge pixel_clk);
        chk("hpos", int'(hpos), ref_h);
        chk("vpos", int'(vpos), ref_v);
        chk("lsync", int'(lsync), int'(!rst && ref_h == -HBL));
        chk("fsync", int'(fsync), int'(!rst && ref_h == -HBL && ref_v == -VBL));
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("rgb", int'(rgb), int'(e.rgb));
            chk("de", int'(de), int'(e.de));
            chk("hsync", int'(hsync), int'(e.hs));
            chk("vsync", int'(vsync), int'(e.vs));
        end
    endtask

    task automatic walk_to(input int h, input int v);
        int k;
        k = 0;
        while (!(ref_h == h && ref_v == v) && k < 400) begin
            tick(1'b0, 1'b0, 24'($urandom), 1'b0, 24'h0, 1'b0);
            k++;
        end
        chk("walk_timeout", k >= 400 ? 1 : 0, 0);
    endtask

    initial begin
        vecs[0] = '{h: 10, v: 3,  act: 1'b1, pix: 24'hEFE62E, rgb: 24'hEFE62E, de: 1'b1};
        vecs[1] = '{h: -5, v: 3,  act: 1'b1, pix: 24'hABCDEF, rgb: 24'h000000, de: 1'b0};
        vecs[2] = '{h: 4,  v: -2, act: 1'b1, pix: 24'h112233, rgb: 24'h000000, de: 1'b0};
        vecs[3] = '{h: 15, v: 7,  act: 1'b1, pix: 24'h010203, rgb: 24'h010203, de: 1'b1};
        vecs[4] = '{h: 0,  v: 0,  act: 1'b0, pix: 24'h777777, rgb: FILL,       de: 1'b1};
        vecs[5] = '{h: -1, v: 0,  act: 1'b0, pix: 24'h000000, rgb: 24'h000000, de: 1'b0};
        vecs[6] = '{h: 0,  v: -1, act: 1'b1, pix: 24'h445566, rgb: 24'h000000, de: 1'b0};

        obj_active = 1'b0;
        obj_pixel  = '0;
        ref_h = -HBL;
        ref_v = -VBL;
        @(negedge pixel_clk);
        repeat (3) tick(1'b1, 1'b0, 24'h0, 1'b0, 24'h0, 1'b0);

        rst = 1'b0;
        #1;
        chk("fsync_release", int'(fsync), 1);
        chk("lsync_release", int'(lsync), 1);

        n_fs = 0; n_ls = 0; n_de = 0; n_hs = 0; n_vs = 0; fs_at = -1;
        for (int c = 1; c <= 700; c++) begin
            tick(1'b0, 1'b0, 24'($urandom), 1'b0, 24'h0, 1'b0);
            if (fsync) begin
                n_fs++;
                if (fs_at < 0) fs_at = c;
            end
            if (lsync) n_ls++;
            if (c <= 350) begin
                if (de) n_de++;
                if (hsync) n_hs++;
                if (vsync) n_vs++;
            end
        end
        chk("fsync_first", fs_at, 350);
        chk("fsync_count", n_fs, 2);
        chk("lsync_count", n_ls, 28);
        chk("de_per_frame", n_de, 128);
        chk("hsync_per_frame", n_hs, 42);
        chk("vsync_per_frame", n_vs, 50);

        for (int i = 0; i < 7; i++) begin
            walk_to(vecs[i].h, vecs[i].v);
            tick(1'b0, vecs[i].act, vecs[i].pix, 1'b1, vecs[i].rgb, vecs[i].de);
        end

        walk_to(5, 4);
        tick(1'b1, 1'b0, 24'h0, 1'b0, 24'h0, 1'b0);
        chk("rst_hpos", int'(hpos), -9);
        chk("rst_vpos", int'(vpos), -6);
        chk("rst_de", int'(de), 0);
        chk("rst_fsync_held", int'(fsync), 0);
        rst = 1'b0;
        #1;
        chk("fsync_after_rst", int'(fsync), 1);
        n = 0;
        repeat (30) begin
            tick(1'b0, 1'b0, 24'($urandom), 1'b0, 24'h0, 1'b0);
            n++;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
